twiddle_factor_gen: RTL

// Full-circle twiddle generator for the FFT datapath: W = exp(-/+j*2*pi*k/n), runtime-sized n = 2^cfg_log2n <= 2^FFT_N.

---
 rtl/twiddle_pkg.sv | 56 +++++
 rtl/twiddle_out_fifo.sv | 53 +++++
 rtl/twiddle_factor_gen.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/twiddle_pkg.sv
// rtl/twiddle_pkg.sv - shared types, constants and quadrant folding for the twiddle generator
package twiddle_pkg;

    // Default geometry: 1024-point maximum transform, 16-bit signed twiddles.
    localparam int TW_FFT_N      = 10;
    localparam int TW_FFT_DW     = 16;
    localparam int TW_ROM_AW     = TW_FFT_N - 2;
    localparam int TW_FULL_SCALE = (1 << (TW_FFT_DW - 1)) - 1;

    // Working width of the quadrant mapper; wide enough for any FFT_DW the top can take.
    localparam int TW_MAP_W = 32;

    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } quadrant_t;

    typedef enum logic {
        SEQ_IDLE   = 1'b0,
        SEQ_SIN_RD = 1'b1
    } seq_state_t;

    // Per-request bookkeeping that travels alongside the ROM reads.
    typedef struct packed {
        logic      valid;
        quadrant_t q;
        logic      ifft;
        logic      sin_zero;
    } tw_tag_t;

    // Rotate the first-quadrant (cos, sin) magnitudes into the full circle and
    // apply the forward/inverse sign on the imaginary part. Returns {real, imag}
    // as two's-complement TW_MAP_W-bit words; callers keep the low bits they need.
    function automatic logic [2*TW_MAP_W-1:0] quad_map(
        input quadrant_t             q,
        input logic [TW_MAP_W-1:0]   cos_mag,
        input logic [TW_MAP_W-1:0]   sin_mag,
        input logic                  inv
    );
        logic [TW_MAP_W-1:0] c;
        logic [TW_MAP_W-1:0] s;
        c = cos_mag;
        s = sin_mag;
        case (q)
            Q0: begin c = cos_mag;  s = sin_mag;  end
            Q1: begin c = -sin_mag; s = cos_mag;  end
            Q2: begin c = -cos_mag; s = -sin_mag; end
            Q3: begin c = sin_mag;  s = -cos_mag; end
            default: begin c = cos_mag; s = sin_mag; end
        endcase
        return {c, (inv ? s : -s)};
    endfunction

endpackage

// File: rtl/twiddle_out_fifo.sv
// rtl/twiddle_out_fifo.sv - 2-entry result buffer absorbing output back-pressure
module twiddle_out_fifo
    import twiddle_pkg::*;
#(
    parameter int WIDTH = 2 * TW_FFT_DW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [1:0]       count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       cnt;

    // Storage, pointers and occupancy; push and pop in one cycle leave the count unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Head entry is presented directly, so it holds steady until popped.
    assign rdata = mem[rd_ptr];
    assign count = cnt;
    assign full  = (cnt == 2'd2);
    assign empty = (cnt == 2'd0);

endmodule

// File: rtl/twiddle_factor_gen.sv
// rtl/twiddle_factor_gen.sv - full-circle twiddle generator over a quarter-wave cosine ROM
module twiddle_factor_gen
    import twiddle_pkg::*;
#(
    parameter int FFT_N   = TW_FFT_N,
    parameter int FFT_DW  = TW_FFT_DW,
    parameter int ROM_LAT = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [3:0]          cfg_log2n,
    input  logic                ifft,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [FFT_N-1:0]    req_k,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [FFT_DW-1:0]   out_real,
    output logic [FFT_DW-1:0]   out_imag,
    output logic                rom_en,
    output logic [FFT_N-3:0]    rom_addr,
    input  logic [FFT_DW-2:0]   rom_data
);

    localparam int ROM_AW = FFT_N - 2;
    // Tag stage i describes the request accepted i cycles ago; the last stage is the FIFO write.
    localparam int PIPE_D = ROM_LAT + 1;

    seq_state_t          state;
    seq_state_t          state_next;
    logic                accept;
    logic [ROM_AW-1:0]   a_reg;

    logic [FFT_N-1:0]    k_masked;
    logic [FFT_N-1:0]    ks;
    logic [4:0]          shamt;

    tw_tag_t             tag_in;
    tw_tag_t             tag_pipe [1:PIPE_D];

    logic [FFT_DW-2:0]   cos_r;
    logic [FFT_DW-2:0]   sin_eff;
    logic [1:0]          inflight;
    logic [2:0]          credits_used;

    logic                push;
    logic                pop;
    logic [2*FFT_DW-1:0] fifo_wdata;
    logic [2*FFT_DW-1:0] fifo_rdata;
    logic [1:0]          fifo_count;
    logic                fifo_full;
    logic                fifo_empty;

    // Map k of an n-point transform onto the N-point index space.
    always_comb begin
        k_masked = req_k & ~({FFT_N{1'b1}} << cfg_log2n);
        shamt    = 5'(FFT_N) - {1'b0, cfg_log2n};
        ks       = k_masked << shamt;
    end

    // ROM sequencer: cos read on the accept cycle, sin read on the next; also owns the request handshake.
    always_comb begin
        state_next   = state;
        req_ready    = 1'b0;
        accept       = 1'b0;
        rom_en       = 1'b0;
        rom_addr     = '0;
        credits_used = {1'b0, fifo_count} + {1'b0, inflight};
        if (!reset) begin
            case (state)
                SEQ_IDLE: begin
                    req_ready = !fifo_full && (credits_used < 3'd2);
                    accept    = req_valid && req_ready;
                    if (accept) begin
                        rom_en     = 1'b1;
                        rom_addr   = ks[ROM_AW-1:0];
                        state_next = SEQ_SIN_RD;
                    end
                end
                SEQ_SIN_RD: begin
                    // N/4 - a in ROM_AW bits; N/4 itself wraps to zero, so this is just -a.
                    rom_en     = 1'b1;
                    rom_addr   = {ROM_AW{1'b0}} - a_reg;
                    state_next = SEQ_IDLE;
                end
                default: state_next = SEQ_IDLE;
            endcase
        end
    end

    // Sequencer state and the first-quadrant offset kept for the sin read.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= SEQ_IDLE;
            a_reg <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                a_reg <= ks[ROM_AW-1:0];
            end
        end
    end

    // Tag for the request being accepted this cycle; a==0 means the sin read aliases cos(0).
    always_comb begin
        tag_in.valid    = accept;
        tag_in.q        = quadrant_t'(ks[FFT_N-1:FFT_N-2]);
        tag_in.ifft     = ifft;
        tag_in.sin_zero = (ks[ROM_AW-1:0] == '0);
    end

    // Tag shift register tracking each request through the ROM latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 1; i <= PIPE_D; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            tag_pipe[1] <= tag_in;
            for (int i = 2; i <= PIPE_D; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    // Hold the cos magnitude until its sin partner arrives one cycle later.
    always_ff @(posedge clk) begin
        if (reset) begin
            cos_r <= '0;
        end else if (tag_pipe[ROM_LAT].valid) begin
            cos_r <= rom_data;
        end
    end

    // Requests accepted but not yet written into the FIFO; counted against the FIFO depth.
    always_ff @(posedge clk) begin
        if (reset) begin
            inflight <= 2'd0;
        end else begin
            case ({accept, push})
                2'b10:   inflight <= inflight + 2'd1;
                2'b01:   inflight <= inflight - 2'd1;
                default: inflight <= inflight;
            endcase
        end
    end

    // The sin word is consumed straight off the ROM bus together with the FIFO write.
    assign push    = tag_pipe[PIPE_D].valid;
    assign sin_eff = tag_pipe[PIPE_D].sin_zero ? '0 : rom_data;

    assign fifo_wdata = {
        FFT_DW'(quad_map(tag_pipe[PIPE_D].q, TW_MAP_W'(cos_r), TW_MAP_W'(sin_eff),
                         tag_pipe[PIPE_D].ifft) >> TW_MAP_W),
        FFT_DW'(quad_map(tag_pipe[PIPE_D].q, TW_MAP_W'(cos_r), TW_MAP_W'(sin_eff),
                         tag_pipe[PIPE_D].ifft))
    };

    assign pop = out_valid && out_ready;

    twiddle_out_fifo #(
        .WIDTH (2 * FFT_DW)
    ) u_out_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign out_real  = fifo_rdata[2*FFT_DW-1:FFT_DW];
    assign out_imag  = fifo_rdata[FFT_DW-1:0];

endmodule
